// File: rtl/activation_execution.sv
// activation_execution: streams a vector from a source buffer tile by tile,
// applies a selectable element-wise activation (pass / ReLU / leaky / clamp)
// and writes each result tile to a destination buffer, honouring write
// back-pressure.
//
// Optional build macro: ACTIVATION_STATS_EN adds zero_count / sat_count.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle request, sampled only when idle
//   mode                0=pass 1=ReLU 2=leaky 3=clamp
//   leaky_shift         arithmetic right shift for negative inputs (leaky)
//   clamp_max           signed upper bound (clamp)
//   src/dest_buffer_id  buffers to read / write
//   length              element count
//   busy, done          status and one-cycle completion pulse
//   vec_read_*          read request / returned tile
//   vec_write_*         write request held until vec_write_ready
//   zero_count, sat_count (ACTIVATION_STATS_EN only)
module activation_execution #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned TILE_WIDTH   = 256,
    parameter int unsigned TILE_ELEMS   = TILE_WIDTH / DATA_WIDTH,
    parameter int unsigned LEN_WIDTH    = 10,
    parameter int unsigned BUF_ID_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [1:0]                           mode,
    input  logic [2:0]                           leaky_shift,
    input  logic signed [DATA_WIDTH-1:0]         clamp_max,
    input  logic [BUF_ID_WIDTH-1:0]              src_buffer_id,
    input  logic [BUF_ID_WIDTH-1:0]              dest_buffer_id,
    input  logic [LEN_WIDTH-1:0]                 length,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 vec_read_enable,
    output logic [BUF_ID_WIDTH-1:0]              vec_read_buffer_id,
    input  logic [TILE_ELEMS*DATA_WIDTH-1:0]     vec_read_tile,
    input  logic                                 vec_read_valid,
    output logic                                 vec_write_enable,
    input  logic                                 vec_write_ready,
    output logic [BUF_ID_WIDTH-1:0]              vec_write_buffer_id,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0]     vec_write_tile
`ifdef ACTIVATION_STATS_EN
    ,
    output logic [LEN_WIDTH:0]                   zero_count,
    output logic [LEN_WIDTH:0]                   sat_count
`endif
);

    localparam int unsigned IDX_W = LEN_WIDTH + 1;
    localparam int unsigned VEC_W = TILE_ELEMS * DATA_WIDTH;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_RELU  = 2'd1;
    localparam logic [1:0] MODE_LEAKY = 2'd2;
    localparam logic [1:0] MODE_CLAMP = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RD,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic [2:0]                     shift_q, shift_d;
    logic signed [DATA_WIDTH-1:0]   cmax_q, cmax_d;
    logic [BUF_ID_WIDTH-1:0]        src_id_q, src_id_d;
    logic [BUF_ID_WIDTH-1:0]        dst_id_q, dst_id_d;
    logic [IDX_W-1:0]               len_q, len_d;
    logic [IDX_W-1:0]               tiles_total_q, tiles_total_d;
    logic [IDX_W-1:0]               tile_idx_q, tile_idx_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           rd_en_q, rd_en_d;
    logic                           wr_en_q, wr_en_d;
    logic [VEC_W-1:0]               wr_tile_q, wr_tile_d;

    logic [IDX_W-1:0]               base_idx;
    logic [VEC_W-1:0]               act_tile;
    logic signed [DATA_WIDTH-1:0]   elem_x;

    // Element-wise activation; result keeps the input width.
    function automatic logic signed [DATA_WIDTH-1:0] activate(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [1:0]                   md,
        input logic [2:0]                   sh,
        input logic signed [DATA_WIDTH-1:0] cm
    );
        logic signed [DATA_WIDTH-1:0] r;
        case (md)
            MODE_PASS:  r = x;
            MODE_RELU:  r = x[DATA_WIDTH-1] ? '0 : x;
            MODE_LEAKY: r = x[DATA_WIDTH-1] ? (x >>> sh) : x;
            default: begin
                // A negative bound collapses every output to zero.
                if (cm[DATA_WIDTH-1] || x[DATA_WIDTH-1]) r = '0;
                else if (x > cm)                         r = cm;
                else                                     r = x;
            end
        endcase
        return r;
    endfunction

    assign base_idx = IDX_W'(tile_idx_q * IDX_W'(TILE_ELEMS));

    // Activated tile with out-of-range tail elements forced to zero.
    always_comb begin
        act_tile = '0;
        elem_x   = '0;
        for (int i = 0; i < int'(TILE_ELEMS); i++) begin
            elem_x = vec_read_tile[i*DATA_WIDTH +: DATA_WIDTH];
            if ((base_idx + IDX_W'(i)) < len_q) begin
                act_tile[i*DATA_WIDTH +: DATA_WIDTH] = activate(elem_x, mode_q, shift_q, cmax_q);
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        cmax_d        = cmax_q;
        src_id_d      = src_id_q;
        dst_id_d      = dst_id_q;
        len_d         = len_q;
        tiles_total_d = tiles_total_q;
        tile_idx_d    = tile_idx_q;
        wr_tile_d     = wr_tile_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d        = mode;
                    shift_d       = leaky_shift;
                    cmax_d        = clamp_max;
                    src_id_d      = src_buffer_id;
                    dst_id_d      = dest_buffer_id;
                    len_d         = IDX_W'(length);
                    tiles_total_d = (IDX_W'(length) + IDX_W'(TILE_ELEMS - 1)) / IDX_W'(TILE_ELEMS);
                    tile_idx_d    = '0;
                    state_d       = (length == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT_RD;
            S_WAIT_RD: begin
                if (vec_read_valid) begin
                    wr_tile_d = act_tile;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (vec_write_ready) begin
                    tile_idx_d = tile_idx_q + IDX_W'(1);
                    state_d    = ((tile_idx_q + IDX_W'(1)) >= tiles_total_q) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered decodes of the upcoming state.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_en_d = (state_d == S_REQ);
        wr_en_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            shift_q       <= '0;
            cmax_q        <= '0;
            src_id_q      <= '0;
            dst_id_q      <= '0;
            len_q         <= '0;
            tiles_total_q <= '0;
            tile_idx_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_tile_q     <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            cmax_q        <= cmax_d;
            src_id_q      <= src_id_d;
            dst_id_q      <= dst_id_d;
            len_q         <= len_d;
            tiles_total_q <= tiles_total_d;
            tile_idx_q    <= tile_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_en_q       <= rd_en_d;
            wr_en_q       <= wr_en_d;
            wr_tile_q     <= wr_tile_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign vec_read_enable     = rd_en_q;
    assign vec_read_buffer_id  = src_id_q;
    assign vec_write_enable    = wr_en_q;
    assign vec_write_buffer_id = dst_id_q;
    assign vec_write_tile      = wr_tile_q;

`ifdef ACTIVATION_STATS_EN
    logic [IDX_W-1:0]             zero_cnt_q, zero_cnt_d;
    logic [IDX_W-1:0]             sat_cnt_q, sat_cnt_d;
    logic [IDX_W-1:0]             tile_zero, tile_sat;
    logic signed [DATA_WIDTH-1:0] st_x, st_y;

    // Per-tile zeroing / saturation counts over in-range elements.
    always_comb begin
        tile_zero = '0;
        tile_sat  = '0;
        st_x      = '0;
        st_y      = '0;
        for (int i = 0; i < int'(TILE_ELEMS); i++) begin
            st_x = vec_read_tile[i*DATA_WIDTH +: DATA_WIDTH];
            st_y = activate(st_x, mode_q, shift_q, cmax_q);
            if ((base_idx + IDX_W'(i)) < len_q) begin
                if ((st_x != '0) && (st_y == '0)) tile_zero = tile_zero + IDX_W'(1);
                if ((mode_q == MODE_CLAMP) && (st_x > cmax_q)) tile_sat = tile_sat + IDX_W'(1);
            end
        end

        zero_cnt_d = zero_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            zero_cnt_d = '0;
            sat_cnt_d  = '0;
        end else if ((state_q == S_WAIT_RD) && vec_read_valid) begin
            zero_cnt_d = zero_cnt_q + tile_zero;
            sat_cnt_d  = sat_cnt_q + tile_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign zero_count = zero_cnt_q;
    assign sat_count  = sat_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_activation_execution.sv
// Self-checking bench for activation_execution: a buffer-controller model with
// random read latency and write back-pressure, checked against an
// element-wise reference model of the activation rules.
module tb_activation_execution;

    localparam int DW = 8;
    localparam int TE = 32;
    localparam int TW = DW * TE;
    localparam int LW = 10;
    localparam int BW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [2:0]    leaky_shift;
    logic [DW-1:0] clamp_max;
    logic [BW-1:0] src_buffer_id;
    logic [BW-1:0] dest_buffer_id;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          vec_read_enable;
    logic [BW-1:0] vec_read_buffer_id;
    logic [TW-1:0] vec_read_tile;
    logic          vec_read_valid;
    logic          vec_write_enable;
    logic          vec_write_ready;
    logic [BW-1:0] vec_write_buffer_id;
    logic [TW-1:0] vec_write_tile;
`ifdef ACTIVATION_STATS_EN
    logic [LW:0]   zero_count;
    logic [LW:0]   sat_count;
`endif

    int errors;
    int checks;
    int src_mem [0:1023];

    activation_execution dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .mode                (mode),
        .leaky_shift         (leaky_shift),
        .clamp_max           (clamp_max),
        .src_buffer_id       (src_buffer_id),
        .dest_buffer_id      (dest_buffer_id),
        .length              (length),
        .busy                (busy),
        .done                (done),
        .vec_read_enable     (vec_read_enable),
        .vec_read_buffer_id  (vec_read_buffer_id),
        .vec_read_tile       (vec_read_tile),
        .vec_read_valid      (vec_read_valid),
        .vec_write_enable    (vec_write_enable),
        .vec_write_ready     (vec_write_ready),
        .vec_write_buffer_id (vec_write_buffer_id),
        .vec_write_tile      (vec_write_tile)
`ifdef ACTIVATION_STATS_EN
        ,
        .zero_count          (zero_count),
        .sat_count           (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference activation from the rules, with floor division for leaky.
    function automatic int ref_act(input int x, input int md, input int sh, input int cm);
        int r;
        case (md)
            0: r = x;
            1: r = (x < 0) ? 0 : x;
            2: r = (x < 0) ? -(((-x) + (1 << sh) - 1) >> sh) : x;
            default: begin
                if (cm < 0 || x < 0) r = 0;
                else if (x > cm)     r = cm;
                else                 r = x;
            end
        endcase
        return r;
    endfunction

    function automatic logic [TW-1:0] ref_tile(input int t, input int md, input int sh,
                                               input int cm, input int len);
        logic [TW-1:0] v;
        int idx;
        int e;
        v = '0;
        for (int i = 0; i < TE; i++) begin
            idx = t * TE + i;
            e = (idx >= len) ? 0 : ref_act(src_mem[idx], md, sh, cm);
            v[i*DW +: DW] = 8'(e);
        end
        return v;
    endfunction

    function automatic logic [TW-1:0] src_tile(input int t);
        logic [TW-1:0] v;
        for (int i = 0; i < TE; i++) v[i*DW +: DW] = 8'(src_mem[t*TE + i]);
        return v;
    endfunction

    function automatic logic [TW-1:0] junk_tile();
        logic [TW-1:0] v;
        for (int i = 0; i < TE; i++) v[i*DW +: DW] = 8'($urandom);
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) src_mem[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    // One job. rmode: 0 ready always high, 1 random ready and stray read
    // valids, 2 ready held low 5 cycles on the first write. abort_read>0
    // returns right after that read request is seen.
    task automatic run_job(input int md, input int sh, input int cm, input int len,
                           input int rmode, input int lat_max, input int abort_read,
                           output int aborted);
        int tiles, rd_cnt, wr_cnt, done_cnt, cd, bp, cyc;
        int exp_zero, exp_sat, x, y;
        bit rd_out, fin, rdy;
        logic [BW-1:0] sid, did;
        logic [TW-1:0] exp_t;

        tiles = (len + TE - 1) / TE;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; cd = 0; bp = 0;
        rd_out = 0; fin = 0; aborted = 0;
        exp_zero = 0; exp_sat = 0;
        for (int i = 0; i < len; i++) begin
            x = src_mem[i];
            y = ref_act(x, md, sh, cm);
            if (x != 0 && y == 0) exp_zero++;
            if (md == 3 && x > cm) exp_sat++;
        end
        sid = BW'($urandom);
        did = BW'($urandom);

        @(negedge clk);
        start = 1'b1; mode = 2'(md); leaky_shift = 3'(sh); clamp_max = 8'(cm);
        src_buffer_id = sid; dest_buffer_id = did; length = LW'(len);

        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                // Only the latched values may matter from here on.
                start = 1'b0;
                mode = 2'($urandom); leaky_shift = 3'($urandom); clamp_max = 8'($urandom);
                src_buffer_id = BW'($urandom); dest_buffer_id = BW'($urandom);
                length = LW'($urandom);
            end
            start = 1'b0;
            vec_read_valid = 1'b0;

            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy_during_job: got %b want 1 (cycle %0d)", busy, cyc);
            end

            if (vec_read_enable) begin
                checks++;
                if (rd_out || rd_cnt != wr_cnt || rd_cnt >= tiles) begin
                    errors++;
                    $display("FAIL read_order: read %0d issued with %0d writes done, want reads==writes<%0d",
                             rd_cnt, wr_cnt, tiles);
                end
                checks++;
                if (vec_read_buffer_id !== sid) begin
                    errors++; $display("FAIL read_id: got %0d want %0d", vec_read_buffer_id, sid);
                end
                rd_out = 1; cd = $urandom_range(1, lat_max);
                rd_cnt++;
                if (abort_read > 0 && rd_cnt == abort_read) begin
                    aborted = 1;
                    return;
                end
            end else if (rd_out) begin
                cd--;
                if (cd == 0) begin
                    vec_read_valid = 1'b1;
                    vec_read_tile = src_tile(rd_cnt - 1);
                    rd_out = 0;
                end
            end else if (rmode == 1 && $urandom_range(0, 5) == 0) begin
                vec_read_valid = 1'b1;
                vec_read_tile = junk_tile();
            end

            if (vec_write_enable) begin
                exp_t = ref_tile(wr_cnt, md, sh, cm, len);
                checks++;
                if (vec_write_tile !== exp_t) begin
                    errors++;
                    $display("FAIL write_tile[%0d]: got %h want %h", wr_cnt, vec_write_tile, exp_t);
                end
                checks++;
                if (vec_write_buffer_id !== did) begin
                    errors++; $display("FAIL write_id: got %0d want %0d", vec_write_buffer_id, did);
                end
                if (rmode == 1)                 rdy = ($urandom_range(0, 2) != 0);
                else if (rmode == 2 && wr_cnt == 0 && bp < 5) begin rdy = 0; bp++; end
                else                            rdy = 1;
                vec_write_ready = rdy;
                if (rdy) wr_cnt++;
            end else begin
                vec_write_ready = (rmode == 1) ? 1'($urandom) : 1'b1;
            end

            if (done) begin
                done_cnt++; fin = 1;
                checks++;
                if (rd_cnt != tiles || wr_cnt != tiles) begin
                    errors++;
                    $display("FAIL traffic: reads %0d writes %0d want %0d each", rd_cnt, wr_cnt, tiles);
                end
`ifdef ACTIVATION_STATS_EN
                checks++;
                if (zero_count !== (LW+1)'(exp_zero) || sat_count !== (LW+1)'(exp_sat)) begin
                    errors++;
                    $display("FAIL stats: got zero=%0d sat=%0d want zero=%0d sat=%0d",
                             zero_count, sat_count, exp_zero, exp_sat);
                end
`endif
            end else if (rmode == 1 && $urandom_range(0, 7) == 0) begin
                start = 1'b1;  // must be ignored while busy
            end
        end

        checks++;
        if (!fin) begin
            errors++; $display("FAIL timeout: done %0d want 1 within budget", done_cnt);
        end
        @(negedge clk);
        start = 1'b0;
        vec_read_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (vec_read_enable !== 1'b0 || vec_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobes: rd=%b wr=%b want 0 0", vec_read_enable, vec_write_enable);
        end
`ifdef ACTIVATION_STATS_EN
        checks++;
        if (zero_count !== (LW+1)'(exp_zero) || sat_count !== (LW+1)'(exp_sat)) begin
            errors++;
            $display("FAIL stats_hold: got zero=%0d sat=%0d want zero=%0d sat=%0d",
                     zero_count, sat_count, exp_zero, exp_sat);
        end
`endif
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_read_enable !== 1'b0 || vec_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL %s_strobes: busy=%b done=%b rd=%b wr=%b want all 0",
                     tag, busy, done, vec_read_enable, vec_write_enable);
        end
        checks++;
        if (vec_read_buffer_id !== '0 || vec_write_buffer_id !== '0) begin
            errors++;
            $display("FAIL %s_ids: rd=%0d wr=%0d want 0 0", tag, vec_read_buffer_id, vec_write_buffer_id);
        end
        checks++;
        if (vec_write_tile !== '0) begin
            errors++; $display("FAIL %s_tile: got %h want 0", tag, vec_write_tile);
        end
`ifdef ACTIVATION_STATS_EN
        checks++;
        if (zero_count !== '0 || sat_count !== '0) begin
            errors++; $display("FAIL %s_stats: zero=%0d sat=%0d want 0 0", tag, zero_count, sat_count);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vec_read_valid = 1'b0; vec_write_ready = 1'b0;
        mode = '0; leaky_shift = '0; clamp_max = '0; src_buffer_id = '0;
        dest_buffer_id = '0; length = '0; vec_read_tile = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_relu_tail();
        int ab;
        fill_random();
        for (int i = 0; i < 32; i++) src_mem[i] = (i % 2 == 0) ? -(i + 1) : (i + 1);
        run_job(1, 0, 0, 40, 0, 2, 0, ab);
    endtask

    task automatic test_leaky();
        int ab;
        fill_random();
        src_mem[0] = -8; src_mem[1] = -5; src_mem[2] = 7; src_mem[3] = -1;
        run_job(2, 2, 0, 4, 0, 1, 0, ab);
    endtask

    task automatic test_clamp();
        int ab;
        fill_random();
        src_mem[0] = -3; src_mem[1] = 0; src_mem[2] = 5;
        src_mem[3] = 6;  src_mem[4] = 7; src_mem[5] = 127;
        run_job(3, 0, 6, 6, 0, 1, 0, ab);
        fill_random();
        run_job(3, 0, -20, 50, 0, 2, 0, ab);   // negative bound zeroes all
    endtask

    task automatic test_back_pressure();
        int ab;
        fill_random();
        run_job(0, 0, 0, 64, 2, 3, 0, ab);
    endtask

    task automatic test_zero_length();
        int ab;
        run_job(1, 0, 0, 0, 0, 1, 0, ab);
    endtask

    task automatic test_reset_mid();
        int ab;
        fill_random();
        run_job(1, 0, 0, 96, 0, 3, 2, ab);
        checks++;
        if (ab != 1) begin
            errors++; $display("FAIL abort_reach: got %0d want 1", ab);
        end
        @(negedge clk);            // DUT now waiting for tile 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_reset");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || vec_read_enable !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: done=%b busy=%b rd=%b want 0 0 0",
                         done, busy, vec_read_enable);
            end
        end
        fill_random();
        run_job(1, 0, 0, 32, 0, 2, 0, ab);
    endtask

    task automatic test_random();
        int ab, md, len;
        for (int j = 0; j < 8; j++) begin
            fill_random();
            md  = $urandom_range(0, 3);
            len = (j == 0) ? 1023 : (j == 1) ? 33 : $urandom_range(1, 200);
            run_job(md, $urandom_range(0, 7), int'($urandom_range(0, 255)) - 128,
                    len, 1, 4, 0, ab);
        end
    endtask

    task automatic test_back_to_back();
        int ab;
        for (int j = 0; j < 3; j++) begin
            fill_random();
            run_job(j + 1, 1, 50, 32 * (j + 1), 0, 1, 0, ab);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_relu_tail();
        test_leaky();
        test_clamp();
        test_back_pressure();
        test_zero_length();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
